// File: rtl/mem_pkg.sv
// Shared encodings and types for the MEM-stage load/store unit.
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEF_RAM_WORDS = 64;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_RMW_WRITE = 1'b1
  } state_t;

  // Sub-word store held across the read-modify-write.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } rmw_req_t;
endpackage

// File: rtl/lane_merge.sv
// Little-endian lane logic: merges store data into a word and extracts/extends a load lane.
module lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] data,
  output logic [31:0] merged,
  output logic [31:0] extracted
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    merged    = word;
    extracted = word;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: begin
        extracted = {{24{b[7] & ~is_unsigned}}, b};
        case (off)
          2'd0:    merged[7:0]   = data[7:0];
          2'd1:    merged[15:8]  = data[7:0];
          2'd2:    merged[23:16] = data[7:0];
          default: merged[31:24] = data[7:0];
        endcase
      end
      SZ_HALF: begin
        extracted = {{16{h[15] & ~is_unsigned}}, h};
        if (off[1]) merged[31:16] = data[15:0];
        else        merged[15:0]  = data[15:0];
      end
      default: begin
        extracted = word;
        merged    = data;
      end
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-only RAM; sub-word stores use a
// registered two-cycle read-modify-write with one stall cycle.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int RAM_WORDS   = DEF_RAM_WORDS,
  parameter int FAULT_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   stall,
  output logic [31:0]            load_data,
  output logic                   misalign,
  output logic                   range_err,
  output logic [FAULT_CNT_W-1:0] fault_cnt,
  output logic [31:0]            ram_addr,
  output logic [31:0]            ram_din,
  output logic                   ram_we,
  input  logic [31:0]            ram_dout
);
  state_t      state, state_nxt;
  rmw_req_t    lat;
  logic [31:0] old_word;

  logic        in_rmw, active, bad_align, word_oor, fault;
  logic [31:0] lm_word, merged, extracted;
  logic [1:0]  lm_off, lm_size;

  always_comb begin
    case (req_size)
      SZ_BYTE: bad_align = 1'b0;
      SZ_HALF: bad_align = req_addr[0];
      SZ_WORD: bad_align = |req_addr[1:0];
      default: bad_align = 1'b1;
    endcase
  end

  assign word_oor  = {2'b00, req_addr[31:2]} >= 32'(RAM_WORDS);
  assign in_rmw    = (state == ST_RMW_WRITE);
  // Faults only mean something for a fresh request seen in IDLE.
  assign active    = !rst && !in_rmw && req_valid;
  assign misalign  = active && bad_align;
  assign range_err = active && word_oor;
  assign fault     = misalign || range_err;

  // One lane_merge serves both paths: live RAM word for loads, latched word for the write-back.
  assign lm_word = in_rmw ? old_word       : ram_dout;
  assign lm_off  = in_rmw ? lat.addr[1:0]  : req_addr[1:0];
  assign lm_size = in_rmw ? lat.size       : req_size;

  lane_merge u_lane_merge (
    .word        (lm_word),
    .off         (lm_off),
    .size        (lm_size),
    .is_unsigned (req_unsigned),
    .data        (lat.wdata),
    .merged      (merged),
    .extracted   (extracted)
  );

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {req_addr[31:2], 2'b00};
    ram_din   = req_wdata;
    load_data = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid && !fault) begin
          if (!req_we)                  load_data = extracted;
          else if (req_size == SZ_WORD) ram_we    = 1'b1;
          else begin
            stall     = 1'b1;
            state_nxt = ST_RMW_WRITE;
          end
        end
      end
      ST_RMW_WRITE: begin
        ram_addr  = {lat.addr[31:2], 2'b00};
        ram_din   = merged;
        ram_we    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Reset wins, including mid-RMW: the pending write is dropped.
    if (rst) begin
      stall     = 1'b0;
      ram_we    = 1'b0;
      load_data = '0;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      old_word  <= '0;
      lat       <= '0;
      fault_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!in_rmw && state_nxt == ST_RMW_WRITE) begin
        old_word  <= ram_dout;
        lat.addr  <= req_addr;
        lat.size  <= req_size;
        lat.wdata <= req_wdata;
      end
      if (fault && !(&fault_cnt)) fault_cnt <= fault_cnt + 1'b1;
    end
  end
endmodule
